// File: rtl/tdc_coarse_capture.sv
`timescale 1ns/1ps
// Coarse TDC front end: fires TDC_start, timestamps up to three synchronised trig edges, holds results until acked.
// Latency: trig edge to capture is sync + 1; res_valid follows the terminating cycle by 1. No backpressure except the res_ack hold.
module tdc_coarse_capture #(
  parameter int CNT_W     = 12,
  parameter int RANGE_CYC = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_req,
  input  logic             res_ack,
  input  logic             trig,
  output logic             TDC_start,
  output logic             busy,
  output logic             res_valid,
  output logic             res_timeout,
  output logic [1:0]       hit_cnt,
  output logic [CNT_W-1:0] hit0,
  output logic [CNT_W-1:0] hit1,
  output logic [CNT_W-1:0] hit2
);

  typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RANGE_CYC - 1);

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic             fin;
  logic             hit;

  assign hit = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt         <= '0;
      fin         <= 1'b0;
      TDC_start   <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
      hit_cnt     <= 2'd0;
      hit0        <= '0;
      hit1        <= '0;
      hit2        <= '0;
    end else begin
      // s3 always tracks s2, so a trig already high at start never looks like an edge
      s1 <= trig;
      s2 <= s1;
      s3 <= s2;
      case (state)
        IDLE: begin
          if (meas_req) begin
            state       <= MEAS;
            TDC_start   <= 1'b1;
            busy        <= 1'b1;
            cnt         <= '0;
            fin         <= 1'b0;
            hit_cnt     <= 2'd0;
            hit0        <= '0;
            hit1        <= '0;
            hit2        <= '0;
            res_timeout <= 1'b0;
          end
        end
        MEAS: begin
          if (fin) begin
            state       <= DONE;
            TDC_start   <= 1'b0;
            res_valid   <= 1'b1;
            res_timeout <= (hit_cnt != 2'd3);
          end else begin
            if (cnt != LAST_CNT) cnt <= cnt + 1'b1;
            if (hit) begin
              case (hit_cnt)
                2'd0:    hit0 <= cnt;
                2'd1:    hit1 <= cnt;
                default: hit2 <= cnt;
              endcase
              hit_cnt <= hit_cnt + 2'd1;
            end
            // A hit in the expiry cycle is captured above before the window closes
            if ((hit && hit_cnt == 2'd2) || cnt == LAST_CNT) fin <= 1'b1;
          end
        end
        DONE: begin
          if (res_ack) begin
            state       <= IDLE;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            hit_cnt     <= 2'd0;
            hit0        <= '0;
            hit1        <= '0;
            hit2        <= '0;
            cnt         <= '0;
            fin         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tdc_coarse_capture.md
# tdc_coarse_capture

Synthesizable coarse-time TDC front end: the receiving end of the APD start/trig interface. On request it raises `TDC_start` to fire the photon detector, counts clock cycles from that edge, and timestamps up to three rising edges on the asynchronous `trig` return line. It stops after three hits or when the range expires. Results are held for the downstream fine-interpolation/readout logic until acknowledged.

## Interface
- `CNT_W`, default 12: coarse counter and timestamp width.
- `RANGE_CYC`, default 2048: measurement window in clock cycles; 2048 ns at the 1 GHz `clk`. Must satisfy 4 ≤ `RANGE_CYC` ≤ 2^`CNT_W`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `meas_req`  in  1  synchronous request; sampled only in IDLE.
- `res_ack`  in  1  synchronous result acknowledge; sampled only in DONE.
- `trig`  in  1  asynchronous photon pulse from the APD, ≥10 ns wide.
- `TDC_start`  out  1  registered; high for the whole measurement window.
- `busy`  out  1  high in MEAS and DONE.
- `res_valid`  out  1  high in DONE.
- `res_timeout`  out  1  valid with `res_valid`; set if the window expired with fewer than 3 hits.
- `hit_cnt`  out  2  number of hits captured, 0–3.
- `hit0`, `hit1`, `hit2`  out  `CNT_W` each  timestamps in cycles, in arrival order; unused slots are 0.

## Operation
- Input sync: `trig` passes through 2 flops (s1, s2) and then a history flop s3. A hit is the condition s2 & ~s3.
- FSM has three states: IDLE, MEAS, DONE.
- **IDLE:** all outputs 0. If `meas_req`=1 at edge E0:
  - next state is MEAS;
  - `TDC_start`←1, `cnt`←0, `hit_cnt`←0, hits←0, `res_timeout`←0;
  - s3←s2, so a `trig` already high at start is not counted.
- **MEAS:** `cnt` increments by 1 every cycle.
  - On a hit, `hit[hit_cnt]`←`cnt` and `hit_cnt`++.
  - If the hit is the third, go to DONE.
  - Else if `cnt`==`RANGE_CYC`−1, go to DONE with `res_timeout`←1 when `hit_cnt` (after the update) <3.
  - A hit in the same cycle as expiry is captured first.
  - Leaving MEAS: `TDC_start`←0.
- **DONE:** `res_valid`=1; outputs are frozen.
  - `res_ack`=1 → IDLE on the next edge.
  - `trig` edges are ignored.
- `meas_req` is ignored outside IDLE. `res_ack` is ignored outside DONE.
- The counter never wraps, because `RANGE_CYC` ≤ 2^`CNT_W`.
- Reset at any time, including mid-MEAS: state IDLE, every output and internal register 0, asynchronously.

## Timing
- `TDC_start` rises at E0. Time t is measured from E0.
- A `trig` rising at t ∈ (k, k+1) ns yields timestamp k+2. This covers 2 sync cycles plus the capture register; the constant offset of 2 is removed downstream.
- A `trig` edge within metastability distance of a clock edge may give ±1.
- Minimum separation between resolvable hits: 2 cycles, since pulses are ≥10 cycles wide.
- `res_valid` rises 1 cycle after the terminating hit is detected or after the expiry cycle.
- `TDC_start` falls on the same edge `res_valid` rises.
- IDLE after ack: 1 cycle. Minimum request-to-request period: window + 3 cycles.

## Test plan
- Three-hit case, with `trig` 10 ns pulses at t = 1000.0625, 1020.125, 1043.75 ns:
  - `hit0`=1002, `hit1`=1022, `hit2`=1045, `hit_cnt`=3, `res_timeout`=0;
  - `TDC_start` falls on the edge after the third capture.
- Single-hit timeout, one pulse at t=500.5:
  - `hit0`=502, `hit1`=`hit2`=0, `hit_cnt`=1, `res_timeout`=1;
  - `res_valid` rises 2049 cycles after E0.
- No-hit case, `trig` held low:
  - `hit_cnt`=0, `res_timeout`=1, all hits 0.
  - Then `res_ack` → IDLE; a new `meas_req` starts cleanly.
- Trig high at start, `trig` held high across E0 and released at t=5:
  - no hit counted;
  - a later pulse at t=100.2 gives `hit0`=102.
- Reset and ignored-input case:
  - Deassert `rst_n` at t=1010 mid-MEAS: all outputs 0 immediately.
  - `meas_req` pulses during MEAS and DONE have no effect.
  - `res_valid` holds ≥50 cycles until `res_ack`.
